// File: rtl/dds_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl_if
//
// Bundles the sweep controller's configuration/control inputs and its
// DDS-facing outputs into one interface.
//
// Signals
//   start    host -> ctrl   level-sampled start request (IDLE/DONE only)
//   abort    host -> ctrl   stop sweep immediately, highest priority
//   f_start  host -> ctrl   first tuning word
//   f_step   host -> ctrl   modular step between tones
//   n_steps  host -> ctrl   steps after the first tone (tones per pass = n+1)
//   dwell    host -> ctrl   dwell count; tone period = dwell+3 clk
//   mode     host -> ctrl   0 single/hold, 1 repeat, 2 triangle, 3 single/gate-off
//   m        ctrl -> DDS    registered tuning word
//   set      ctrl -> DDS    registered one-cycle load strobe
//   en       ctrl -> DDS    registered output enable
//   busy     ctrl -> host   sweep in progress
//   done     ctrl -> host   one-cycle pulse on entry to DONE
//   pass     ctrl -> host   one-cycle pulse at the end of each pass
//
// Modports
//   master : host/testbench side (drives config, observes outputs)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface dds_sweep_ctrl_if #(
  parameter int unsigned W  = 40,
  parameter int unsigned CW = 16,
  parameter int unsigned DW = 24
);

  logic          start;
  logic          abort;
  logic [W-1:0]  f_start;
  logic [W-1:0]  f_step;
  logic [CW-1:0] n_steps;
  logic [DW-1:0] dwell;
  logic [1:0]    mode;

  logic [W-1:0]  m;
  logic          set;
  logic          en;
  logic          busy;
  logic          done;
  logic          pass;

  modport master (
    output start, abort, f_start, f_step, n_steps, dwell, mode,
    input  m, set, en, busy, done, pass
  );

  modport slave (
    input  start, abort, f_start, f_step, n_steps, dwell, mode,
    output m, set, en, busy, done, pass
  );

endinterface

// File: rtl/dds_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// dds_sweep_ctrl
//
// Stepped-frequency sweep sequencer for a DDS core. On start it captures the
// sweep configuration into shadow registers, then for each tone updates the
// tuning word m, waits one cycle for m to settle, pulses set for one cycle and
// dwells. Supports single-shot (hold or gate-off), repeat and triangle modes.
// All m arithmetic is modulo 2^W.
//
// Ports
//   clk    DDS clock
//   rst_n  asynchronous active-low reset
//   bus    dds_sweep_ctrl_if.slave: config/control in, m/set/en/busy/done/pass out
//
// Timing per tone (registered outputs):
//   edge k   : state -> UPD, m updated
//   edge k+1 : state -> PULSE
//   edge k+2 : state -> DWELL, set rises (high one cycle)
//   dwell+1 cycles in DWELL, then next tone -> period dwell+3 clk.
// The interface widths must match W/CW/DW.
// ---------------------------------------------------------------------------
module dds_sweep_ctrl #(
  parameter int unsigned W  = 40,
  parameter int unsigned CW = 16,
  parameter int unsigned DW = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  dds_sweep_ctrl_if.slave   bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StUpd   = 3'd1;
  localparam logic [2:0] StPulse = 3'd2;
  localparam logic [2:0] StDwell = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [1:0] ModeHold    = 2'd0;
  localparam logic [1:0] ModeRepeat  = 2'd1;
  localparam logic [1:0] ModeTri     = 2'd2;
  localparam logic [1:0] ModeGateOff = 2'd3;

  localparam logic [CW-1:0] IdxZero = '0;
  localparam logic [CW-1:0] IdxOne  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] CntZero = '0;
  localparam logic [DW-1:0] CntOne  = {{(DW-1){1'b0}}, 1'b1};

  // Sequencer state
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          dir_q, dir_d;     // 0 = ascending, 1 = descending
  logic [DW-1:0] cnt_q, cnt_d;

  // Shadow copy of the configuration, frozen for the whole sweep
  logic [W-1:0]  fstart_q, fstart_d;
  logic [W-1:0]  fstep_q, fstep_d;
  logic [CW-1:0] nsteps_q, nsteps_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    mode_q, mode_d;

  // Registered outputs
  logic [W-1:0]  m_q, m_d;
  logic          set_q, set_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;

  // Next tone in the current direction and in the reversed direction
  logic [W-1:0]  m_fwd, m_rev;

  always_comb begin
    m_fwd = dir_q ? (m_q - fstep_q) : (m_q + fstep_q);
    m_rev = dir_q ? (m_q + fstep_q) : (m_q - fstep_q);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    fstart_d = fstart_q;
    fstep_d  = fstep_q;
    nsteps_d = nsteps_q;
    dwell_d  = dwell_q;
    mode_d   = mode_q;
    m_d      = m_q;
    en_d     = en_q;
    set_d    = 1'b0;
    done_d   = 1'b0;
    pass_d   = 1'b0;

    if (bus.abort) begin
      // Abort wins over everything, including a start in the same cycle.
      // m keeps its value so the DDS output is merely gated.
      state_d = StIdle;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            fstart_d = bus.f_start;
            fstep_d  = bus.f_step;
            nsteps_d = bus.n_steps;
            dwell_d  = bus.dwell;
            mode_d   = bus.mode;
            m_d      = bus.f_start;
            idx_d    = IdxZero;
            dir_d    = 1'b0;
            en_d     = 1'b1;
            state_d  = StUpd;
          end
        end

        // m settles for a full cycle here before set rises.
        StUpd: begin
          en_d    = 1'b1;
          state_d = StPulse;
        end

        StPulse: begin
          set_d   = 1'b1;
          cnt_d   = dwell_q;
          state_d = StDwell;
        end

        StDwell: begin
          if (cnt_q != CntZero) begin
            cnt_d = cnt_q - CntOne;
          end else if (idx_q < nsteps_q) begin
            idx_d   = idx_q + IdxOne;
            m_d     = m_fwd;
            state_d = StUpd;
          end else begin
            pass_d = 1'b1;
            unique case (mode_q)
              ModeHold: begin
                done_d  = 1'b1;
                state_d = StDone;
              end
              ModeGateOff: begin
                done_d  = 1'b1;
                en_d    = 1'b0;
                state_d = StDone;
              end
              ModeRepeat: begin
                m_d     = fstart_q;
                idx_d   = IdxZero;
                state_d = StUpd;
              end
              ModeTri: begin
                // Reverse and step immediately so the endpoint tone is not
                // repeated; a single-tone sweep just re-pulses the same word.
                dir_d = ~dir_q;
                if (nsteps_q != IdxZero) begin
                  idx_d = IdxOne;
                  m_d   = m_rev;
                end
                state_d = StUpd;
              end
              default: state_d = StDone;
            endcase
          end
        end

        default: begin
          state_d = StIdle;
          en_d    = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == StUpd) || (state_d == StPulse) || (state_d == StDwell);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      fstart_q <= '0;
      fstep_q  <= '0;
      nsteps_q <= '0;
      dwell_q  <= '0;
      mode_q   <= '0;
      m_q      <= '0;
      set_q    <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      fstart_q <= fstart_d;
      fstep_q  <= fstep_d;
      nsteps_q <= nsteps_d;
      dwell_q  <= dwell_d;
      mode_q   <= mode_d;
      m_q      <= m_d;
      set_q    <= set_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign bus.m    = m_q;
  assign bus.set  = set_q;
  assign bus.en   = en_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: linear stimulus, immediate-assertion checks.
module tb_dds_sweep_ctrl;

  localparam int unsigned W  = 40;
  localparam int unsigned CW = 16;
  localparam int unsigned DW = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if #(.W(W), .CW(CW), .DW(DW)) bus ();

  dds_sweep_ctrl #(.W(W), .CW(CW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int c0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every set pulse with its word, the word one cycle earlier,
  // its cycle and the number of pass pulses seen so far.
  logic [W-1:0] m_last = '0;
  logic [W-1:0] sm[$];
  logic [W-1:0] sp[$];
  int           sc[$];
  int           spass[$];
  int           done_cnt = 0;
  int           pass_cnt = 0;

  always @(negedge clk) begin
    if (bus.set === 1'b1) begin
      sm.push_back(bus.m);
      sp.push_back(m_last);
      sc.push_back(cyc);
      spass.push_back(pass_cnt);
    end
    if (bus.done === 1'b1) done_cnt++;
    if (bus.pass === 1'b1) pass_cnt++;
    m_last = bus.m;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    sm.delete();
    sp.delete();
    sc.delete();
    spass.delete();
    done_cnt = 0;
    pass_cnt = 0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic go(input logic [W-1:0] fs, input logic [W-1:0] st, input int n,
                    input int dw, input logic [1:0] md);
    bus.f_start = fs;
    bus.f_step  = st;
    bus.n_steps = CW'(n);
    bus.dwell   = DW'(dw);
    bus.mode    = md;
    bus.start   = 1'b1;
    c0 = cyc;
    run(1);
    bus.start = 1'b0;
  endtask

  // Check a 4-tone up-sweep of 0x0100000000 + k*0x0010000000, period 5.
  task automatic chk_sweep4(input string tag);
    logic [W-1:0] e;
    chk({tag, "_nset"}, 64'(sm.size()), 64'd4);
    for (int i = 0; i < 4 && i < sm.size(); i++) begin
      e = 40'h01_0000_0000 + 40'(i) * 40'h00_1000_0000;
      chk({tag, "_m"}, 64'(sm[i]), 64'(e));
      chk({tag, "_mstable"}, 64'(sp[i]), 64'(e));
      chk({tag, "_time"}, 64'(sc[i] - c0), 64'(3 + 5 * i));
    end
  endtask

  logic [W-1:0] tri_exp [7];
  logic [W-1:0] wrap_exp [4];

  initial begin
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.f_start = '0;
    bus.f_step  = '0;
    bus.n_steps = '0;
    bus.dwell   = '0;
    bus.mode    = '0;
    tri_exp  = '{40'd10, 40'd11, 40'd12, 40'd11, 40'd10, 40'd11, 40'd12};
    wrap_exp = '{40'hFF_FFFF_FFF0, 40'h00_0000_0010, 40'hFF_FFFF_FFF0, 40'h00_0000_0010};

    // Reset values
    run(2);
    chk("rst_m", 64'(bus.m), 64'd0);
    chk("rst_set", 64'(bus.set), 64'd0);
    chk("rst_en", 64'(bus.en), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_pass", 64'(bus.pass), 64'd0);
    rst_n = 1'b1;
    run(2);

    // Mode 0: single sweep, last tone held
    clr();
    go(40'h01_0000_0000, 40'h00_1000_0000, 3, 2, 2'd0);
    chk("m0_busy", 64'(bus.busy), 64'd1);
    chk("m0_en_upd", 64'(bus.en), 64'd1);
    run(24);
    chk_sweep4("m0");
    chk("m0_done", 64'(done_cnt), 64'd1);
    chk("m0_pass", 64'(pass_cnt), 64'd1);
    chk("m0_en", 64'(bus.en), 64'd1);
    chk("m0_busy_end", 64'(bus.busy), 64'd0);
    chk("m0_mhold", 64'(bus.m), 64'h01_3000_0000);

    // Mode 3: same sweep re-armed from DONE, output gated at the end
    clr();
    go(40'h01_0000_0000, 40'h00_1000_0000, 3, 2, 2'd3);
    run(24);
    chk_sweep4("m3");
    chk("m3_done", 64'(done_cnt), 64'd1);
    chk("m3_pass", 64'(pass_cnt), 64'd1);
    chk("m3_en", 64'(bus.en), 64'd0);
    chk("m3_busy", 64'(bus.busy), 64'd0);

    // Mode 2: triangle 10..12..10.., period 3
    clr();
    go(40'd10, 40'd1, 2, 0, 2'd2);
    run(21);
    chk("tri_nset", 64'(sm.size()), 64'd7);
    for (int i = 0; i < 7 && i < sm.size(); i++) begin
      chk("tri_m", 64'(sm[i]), 64'(tri_exp[i]));
      chk("tri_time", 64'(sc[i] - c0), 64'(3 + 3 * i));
    end
    if (sm.size() >= 7) begin
      chk("tri_pass1", 64'(spass[3]), 64'd1);
      chk("tri_pass2", 64'(spass[5]), 64'd2);
    end
    chk("tri_done", 64'(done_cnt), 64'd0);
    chk("tri_busy", 64'(bus.busy), 64'd1);
    bus.abort = 1'b1;
    run(1);
    bus.abort = 1'b0;
    chk("tri_abort_busy", 64'(bus.busy), 64'd0);
    chk("tri_abort_en", 64'(bus.en), 64'd0);

    // Mode 1: repeat with wrap-around, period 4
    clr();
    go(40'hFF_FFFF_FFF0, 40'h20, 1, 1, 2'd1);
    run(17);
    chk("wrap_nset", 64'(sm.size()), 64'd4);
    for (int i = 0; i < 4 && i < sm.size(); i++) begin
      chk("wrap_m", 64'(sm[i]), 64'(wrap_exp[i]));
      chk("wrap_time", 64'(sc[i] - c0), 64'(3 + 4 * i));
    end
    if (sm.size() >= 3) chk("wrap_pass_mid", 64'(spass[2]), 64'd1);
    chk("wrap_pass", 64'(pass_cnt), 64'd2);
    chk("wrap_done", 64'(done_cnt), 64'd0);
    bus.abort = 1'b1;
    run(1);
    bus.abort = 1'b0;
    run(3);

    // Abort during the dwell of tone 2
    clr();
    go(40'h01_0000_0000, 40'h00_1000_0000, 3, 2, 2'd0);
    run(8);
    bus.abort = 1'b1;
    run(1);
    bus.abort = 1'b0;
    chk("ab_set", 64'(bus.set), 64'd0);
    chk("ab_en", 64'(bus.en), 64'd0);
    chk("ab_busy", 64'(bus.busy), 64'd0);
    chk("ab_m", 64'(bus.m), 64'h01_1000_0000);
    run(10);
    chk("ab_nset", 64'(sm.size()), 64'd2);
    chk("ab_done", 64'(done_cnt), 64'd0);
    chk("ab_pass", 64'(pass_cnt), 64'd0);
    chk("ab_mhold", 64'(bus.m), 64'h01_1000_0000);

    // Abort in the same cycle as start, straight after reset
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(1);
    clr();
    bus.abort = 1'b1;
    go(40'h01_0000_0000, 40'h00_1000_0000, 3, 2, 2'd0);
    bus.abort = 1'b0;
    chk("abs_m", 64'(bus.m), 64'd0);
    chk("abs_en", 64'(bus.en), 64'd0);
    chk("abs_busy", 64'(bus.busy), 64'd0);
    run(10);
    chk("abs_nset", 64'(sm.size()), 64'd0);
    chk("abs_done", 64'(done_cnt), 64'd0);

    // Input changes and start while busy are ignored
    clr();
    go(40'h01_0000_0000, 40'h00_1000_0000, 3, 2, 2'd0);
    run(4);
    bus.f_start = 40'h55_5555_5555;
    bus.dwell   = DW'(7);
    bus.mode    = 2'd1;
    bus.start   = 1'b1;
    run(1);
    bus.start = 1'b0;
    run(19);
    chk_sweep4("busy");
    chk("busy_done", 64'(done_cnt), 64'd1);
    chk("busy_busy", 64'(bus.busy), 64'd0);

    // Asynchronous reset while in PULSE
    clr();
    go(40'h01_0000_0000, 40'h00_1000_0000, 3, 2, 2'd0);
    run(1);
    chk("pr_en_pre", 64'(bus.en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("pr_set", 64'(bus.set), 64'd0);
    chk("pr_en", 64'(bus.en), 64'd0);
    chk("pr_m", 64'(bus.m), 64'd0);
    chk("pr_busy", 64'(bus.busy), 64'd0);
    run(3);
    rst_n = 1'b1;
    run(6);
    chk("pr_nset", 64'(sm.size()), 64'd0);
    chk("pr_m_after", 64'(bus.m), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
